jamma_joy_scan: RTL and testbench

- Time-multiplexed JAMMA joystick scanner: the successor to the fixed two-phase JSELECT toggle in the arcade top levels.
- Drives a select code onto the shared JAMMA harness and waits a programmable settle time before sampling each player's bus.
- Debounces every bit per player and merges the on-board DB9 joystick into player 1.
- Sits between the JJOY/JSELECT pins and the core's I_JOYSTICK_x / I_PLAYER inputs. Generalises player count, bus width, settle time and debounce depth.

---
 rtl/jamma_pkg.sv | 35 +++
 rtl/jamma_debounce.sv | 46 ++++
 rtl/jamma_joy_scan.sv | 123 ++++++++++++
 tb/tb_jamma_joy_scan.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jamma_pkg.sv
// Shared JAMMA definitions: harness bit positions, scan FSM states, helpers.
// No logic of its own; zero latency.
// No flow control; constants and pure functions only.
package jamma_pkg;

  // Bit positions on an active-low JAMMA player bus
  localparam int JAMMA_UP    = 0;
  localparam int JAMMA_DOWN  = 1;
  localparam int JAMMA_LEFT  = 2;
  localparam int JAMMA_RIGHT = 3;
  localparam int JAMMA_FIRE1 = 4;
  localparam int JAMMA_FIRE2 = 5;
  localparam int JAMMA_START = 6;
  localparam int JAMMA_SPARE = 7;

  // The DB9 joystick covers directions plus two fire buttons
  localparam int JAMMA_LOCAL_W = 6;

  // Idle level of an 8-bit active-low player bus (nothing pressed)
  localparam logic [7:0] JAMMA_RELEASED = 8'hFF;

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_SAMPLE = 1'b1
  } scan_state_t;

  // Active-low merge: a press on either source reads as pressed
  function automatic logic [JAMMA_LOCAL_W-1:0] merge_local(
    input logic [JAMMA_LOCAL_W-1:0] bus,
    input logic [JAMMA_LOCAL_W-1:0] loc
  );
    return bus & loc;
  endfunction

endpackage

// File: rtl/jamma_debounce.sv
// Per-bit debounce of one player bus; a bit flips after DEB_MAX differing samples.
// Output registered on the enabled edge, visible the following cycle.
// No backpressure; samples are taken only when i_en is high.
module jamma_debounce
  import jamma_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEB_BITS = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_s,
  output logic [WIDTH-1:0] o_state
);

  // Counter value on which the next differing sample reaches 2^DEB_BITS-1
  localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'((1 << DEB_BITS) - 2);

  logic [WIDTH-1:0]    r_state;
  logic [DEB_BITS-1:0] r_cnt [WIDTH];

  // Count consecutive disagreeing samples per bit; flip once the run is long enough
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= '1;
      for (int b = 0; b < WIDTH; b++) begin
        r_cnt[b] <= '0;
      end
    end else if (i_en) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (i_s[b] == r_state[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == DEB_LAST) begin
          r_state[b] <= ~r_state[b];
          r_cnt[b]   <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + DEB_BITS'(1);
        end
      end
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/jamma_joy_scan.sv
// Time-multiplexed JAMMA scanner: select, settle, sample and debounce each player.
// Input flop adds 1 cycle; outputs update the cycle after each channel's sample.
// No backpressure; free-running scan with a scan_done pulse per full pass.
module jamma_joy_scan
  import jamma_pkg::*;
#(
  parameter int NPLAYERS = 2,
  parameter int SELW     = 1,
  parameter int WIDTH    = 8,
  parameter int SETTLE   = 4,
  parameter int DEB_BITS = 2
) (
  input  logic                      pclk,
  input  logic                      pll_lckd,
  input  logic [WIDTH-1:0]          jjoy,
  input  logic [JAMMA_LOCAL_W-1:0]  local_joy,
  output logic [SELW-1:0]           jselect,
  output logic [NPLAYERS*WIDTH-1:0] joy_out,
  output logic                      scan_done,
  output logic                      valid
);

  localparam int                CNTW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNTW-1:0]   SETTLE_RELOAD = CNTW'(SETTLE - 1);
  localparam logic [SELW-1:0]   SEL_LAST      = SELW'(NPLAYERS - 1);

  // Parameter sanity, caught at elaboration
  if (SETTLE < 1) begin : g_chk_settle
    $error("jamma_joy_scan: SETTLE must be at least 1");
  end
  if (NPLAYERS < 2) begin : g_chk_nplayers
    $error("jamma_joy_scan: NPLAYERS must be at least 2");
  end
  if (NPLAYERS > (1 << SELW)) begin : g_chk_selw
    $error("jamma_joy_scan: SELW too narrow for NPLAYERS");
  end
  if (WIDTH < JAMMA_LOCAL_W) begin : g_chk_width
    $error("jamma_joy_scan: WIDTH must cover the local joystick bits");
  end

  logic [WIDTH-1:0]         r_jjoy;
  logic [JAMMA_LOCAL_W-1:0] r_local;
  scan_state_t              r_state;
  logic [CNTW-1:0]          r_settle;
  logic [SELW-1:0]          r_sel;
  logic                     r_done;
  logic                     r_valid;
  logic                     w_sample;
  logic [WIDTH-1:0]         w_s0;

  // Single flop on the asynchronous harness and DB9 pins
  always_ff @(posedge pclk or negedge pll_lckd) begin
    if (!pll_lckd) begin
      r_jjoy  <= '1;
      r_local <= '1;
    end else begin
      r_jjoy  <= jjoy;
      r_local <= local_joy;
    end
  end

  // Scan FSM: hold each select for SETTLE cycles, then spend one cycle sampling it
  always_ff @(posedge pclk or negedge pll_lckd) begin
    if (!pll_lckd) begin
      r_state  <= ST_SETTLE;
      r_settle <= SETTLE_RELOAD;
      r_sel    <= '0;
      r_done   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_settle <= r_settle - CNTW'(1);
          end
        end
        ST_SAMPLE: begin
          r_state  <= ST_SETTLE;
          r_settle <= SETTLE_RELOAD;
          if (r_sel == SEL_LAST) begin
            r_sel   <= '0;
            r_done  <= 1'b1;
            r_valid <= 1'b1;
          end else begin
            r_sel <= r_sel + SELW'(1);
          end
        end
      endcase
    end
  end

  assign w_sample = (r_state == ST_SAMPLE);

  // Player 0 also sees the on-board DB9 stick on its low bits
  always_comb begin
    w_s0                      = r_jjoy;
    w_s0[JAMMA_LOCAL_W-1:0]   = merge_local(r_jjoy[JAMMA_LOCAL_W-1:0], r_local);
  end

  for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
    logic w_en;
    assign w_en = w_sample && (r_sel == SELW'(p));

    jamma_debounce #(
      .WIDTH    (WIDTH),
      .DEB_BITS (DEB_BITS)
    ) u_deb (
      .i_clk   (pclk),
      .i_rst_n (pll_lckd),
      .i_en    (w_en),
      .i_s     ((p == 0) ? w_s0 : r_jjoy),
      .o_state (joy_out[p*WIDTH +: WIDTH])
    );
  end

  assign jselect   = r_sel;
  assign scan_done = r_done;
  assign valid     = r_valid;

endmodule

// File: tb/tb_jamma_joy_scan.sv
// Bench for jamma_joy_scan: a 2-player and a 3-player instance share clock, reset and DB9.
// Each instance reads its own harness bus, emulated as pbus[jselect].
// A cycle-indexed reference model predicts selects, pulses and debounced outputs.
module tb_jamma_joy_scan;

  localparam int SETTLE   = 4;
  localparam int DEB_BITS = 2;
  localparam int P        = SETTLE + 1;
  localparam int DEB_MAX  = (1 << DEB_BITS) - 1;

  logic             pclk = 1'b0;
  logic             pll_lckd = 1'b0;
  logic [3:0][7:0]  pbus;
  logic [5:0]       local_joy;
  logic [7:0]       jjoy_a, jjoy_b;
  logic [0:0]       sel_a;
  logic [1:0]       sel_b;
  logic [15:0]      joy_a;
  logic [23:0]      joy_b;
  logic             done_a, done_b, valid_a, valid_b;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  // Harness: the bus shows whichever player the scanner selects
  assign jjoy_a = pbus[sel_a];
  assign jjoy_b = pbus[sel_b];

  jamma_joy_scan #(.NPLAYERS(2), .SELW(1), .WIDTH(8), .SETTLE(SETTLE), .DEB_BITS(DEB_BITS)) dut_a (
    .pclk(pclk), .pll_lckd(pll_lckd), .jjoy(jjoy_a), .local_joy(local_joy),
    .jselect(sel_a), .joy_out(joy_a), .scan_done(done_a), .valid(valid_a)
  );

  jamma_joy_scan #(.NPLAYERS(3), .SELW(2), .WIDTH(8), .SETTLE(SETTLE), .DEB_BITS(DEB_BITS)) dut_b (
    .pclk(pclk), .pll_lckd(pll_lckd), .jjoy(jjoy_b), .local_joy(local_joy),
    .jselect(sel_b), .joy_out(joy_b), .scan_done(done_b), .valid(valid_b)
  );

  // ---------------- reference model ----------------
  int                            m_cyc;   // cycles since reset release
  logic [1:0][2:0][7:0]          m_out;   // [instance][player] debounced bus
  logic [1:0][2:0][7:0][DEB_BITS-1:0] m_cnt;
  logic [3:0][7:0]               m_pb;    // player buses as seen through the input flop
  logic [5:0]                    m_loc;

  function automatic int np_of(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int chan_of(input int d, input int c);
    return (c / P) % np_of(d);
  endfunction

  function automatic logic samp_bit(input int ch, input int b);
    logic [7:0] s;
    s = m_pb[ch];
    if (ch == 0) s[5:0] = s[5:0] & m_loc;
    return s[b];
  endfunction

  function automatic logic exp_done(input int d, input int c);
    return (c > 0) && (c % (np_of(d) * P) == 0);
  endfunction

  function automatic logic exp_valid(input int d, input int c);
    return c >= np_of(d) * P;
  endfunction

  function automatic logic [15:0] exp_joy_a();
    return {m_out[0][1], m_out[0][0]};
  endfunction

  function automatic logic [23:0] exp_joy_b();
    return {m_out[1][2], m_out[1][1], m_out[1][0]};
  endfunction

  always @(posedge pclk or negedge pll_lckd) begin
    if (!pll_lckd) begin
      m_cyc <= 0;
      m_pb  <= '1;
      m_loc <= '1;
      m_out <= '1;
      m_cnt <= '0;
    end else begin
      if (m_cyc % P == SETTLE) begin
        for (int d = 0; d < 2; d++) begin
          for (int ch = 0; ch < 3; ch++) begin
            if (ch == chan_of(d, m_cyc)) begin
              for (int b = 0; b < 8; b++) begin
                if (samp_bit(ch, b) == m_out[d][ch][b]) begin
                  m_cnt[d][ch][b] <= '0;
                end else if (int'(m_cnt[d][ch][b]) + 1 >= DEB_MAX) begin
                  m_out[d][ch][b] <= ~m_out[d][ch][b];
                  m_cnt[d][ch][b] <= '0;
                end else begin
                  m_cnt[d][ch][b] <= m_cnt[d][ch][b] + DEB_BITS'(1);
                end
              end
            end
          end
        end
      end
      m_pb  <= pbus;
      m_loc <= local_joy;
      m_cyc <= m_cyc + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    @(negedge pclk);
    pll_lckd  = 1'b0;
    pbus      = '1;
    local_joy = '1;
    repeat (2) @(negedge pclk);
  endtask

  task automatic release_reset();
    pll_lckd = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c;
    apply_reset();
    #1;
    total++; if (sel_a !== 1'b0)        begin bad++; $display("FAIL rst_sel_a got=%0d want=0", sel_a); end
    total++; if (sel_b !== 2'd0)        begin bad++; $display("FAIL rst_sel_b got=%0d want=0", sel_b); end
    total++; if (joy_a !== 16'hFFFF)    begin bad++; $display("FAIL rst_joy_a got=%h want=ffff", joy_a); end
    total++; if (joy_b !== 24'hFFFFFF)  begin bad++; $display("FAIL rst_joy_b got=%h want=ffffff", joy_b); end
    total++; if (done_a !== 1'b0 || done_b !== 1'b0)   begin bad++; $display("FAIL rst_done got=%b%b want=00", done_a, done_b); end
    total++; if (valid_a !== 1'b0 || valid_b !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b%b want=00", valid_a, valid_b); end
    release_reset();
    #1;
    total++; if (sel_a !== 1'b0 || valid_a !== 1'b0) begin bad++; $display("FAIL rel_cyc0 sel=%0d valid=%b want 0/0", sel_a, valid_a); end
    repeat (35) begin
      @(negedge pclk);
      c = m_cyc;
      total++; if (sel_a !== 1'((c % 10) >= 5)) begin bad++; $display("FAIL seq_sel_a cyc=%0d got=%0d want=%0d", c, sel_a, (c % 10) >= 5); end
      total++; if (done_a !== 1'(c > 0 && c % 10 == 0)) begin bad++; $display("FAIL seq_done_a cyc=%0d got=%b", c, done_a); end
      total++; if (valid_a !== 1'(c >= 10)) begin bad++; $display("FAIL seq_valid_a cyc=%0d got=%b", c, valid_a); end
      total++; if (joy_a !== 16'hFFFF) begin bad++; $display("FAIL seq_joy_a cyc=%0d got=%h want=ffff", c, joy_a); end
    end
  endtask

  task automatic test_settle_debounce();
    int c;
    apply_reset();
    pbus[1][0] = 1'b0;
    release_reset();
    repeat (45) begin
      @(negedge pclk);
      c = m_cyc;
      total++; if (joy_a[8] !== 1'(c < 30)) begin bad++; $display("FAIL settle_a8 cyc=%0d got=%b want=%b", c, joy_a[8], c < 30); end
      total++; if (joy_a[7:0] !== 8'hFF) begin bad++; $display("FAIL settle_a_p0 cyc=%0d got=%h want=ff", c, joy_a[7:0]); end
      total++; if (joy_b[8] !== 1'(c < 40)) begin bad++; $display("FAIL settle_b8 cyc=%0d got=%b want=%b", c, joy_b[8], c < 40); end
      total++; if (joy_b !== exp_joy_b()) begin bad++; $display("FAIL settle_joy_b cyc=%0d got=%h want=%h", c, joy_b, exp_joy_b()); end
    end
  endtask

  task automatic test_glitch();
    int c;
    int n;
    apply_reset();
    release_reset();
    n = 0;
    while (m_cyc % 10 != 5 && n < 12) begin @(negedge pclk); n++; end
    total++; if (m_cyc % 10 != 5) begin bad++; $display("FAIL glitch_align cyc=%0d", m_cyc); end
    // two 2-sample glitches; a counter that failed to clear would flip on the second
    repeat (2) begin
      pbus[0][4] = 1'b0;
      repeat (20) begin
        @(negedge pclk);
        c = m_cyc;
        total++; if (joy_a[4] !== 1'b1) begin bad++; $display("FAIL glitch_a4 cyc=%0d got=%b want=1", c, joy_a[4]); end
        total++; if (joy_b !== exp_joy_b()) begin bad++; $display("FAIL glitch_joy_b cyc=%0d got=%h want=%h", c, joy_b, exp_joy_b()); end
      end
      pbus[0][4] = 1'b1;
      repeat (10) begin
        @(negedge pclk);
        c = m_cyc;
        total++; if (joy_a !== 16'hFFFF) begin bad++; $display("FAIL glitch_after cyc=%0d got=%h want=ffff", c, joy_a); end
      end
    end
  endtask

  task automatic test_local_merge();
    int c;
    apply_reset();
    local_joy[2] = 1'b0;
    release_reset();
    repeat (45) begin
      @(negedge pclk);
      c = m_cyc;
      total++; if (joy_a[2] !== 1'(c < 25)) begin bad++; $display("FAIL local_a2 cyc=%0d got=%b want=%b", c, joy_a[2], c < 25); end
      total++; if (joy_a[10] !== 1'b1) begin bad++; $display("FAIL local_a10 cyc=%0d got=%b want=1", c, joy_a[10]); end
      total++; if (joy_b[2] !== 1'(c < 35)) begin bad++; $display("FAIL local_b2 cyc=%0d got=%b want=%b", c, joy_b[2], c < 35); end
      total++; if (joy_b[10] !== 1'b1 || joy_b[18] !== 1'b1) begin bad++; $display("FAIL local_b_other cyc=%0d got=%h", c, joy_b); end
    end
  endtask

  task automatic test_wrap();
    int c;
    apply_reset();
    release_reset();
    repeat (65) begin
      @(negedge pclk);
      c = m_cyc;
      total++; if (sel_b === 2'd3) begin bad++; $display("FAIL wrap_sel3 cyc=%0d got=3", c); end
      total++; if (sel_b !== 2'((c / 5) % 3)) begin bad++; $display("FAIL wrap_sel_b cyc=%0d got=%0d want=%0d", c, sel_b, (c / 5) % 3); end
      total++; if (done_b !== 1'(c > 0 && c % 15 == 0)) begin bad++; $display("FAIL wrap_done_b cyc=%0d got=%b", c, done_b); end
      total++; if (valid_b !== 1'(c >= 15)) begin bad++; $display("FAIL wrap_valid_b cyc=%0d got=%b", c, valid_b); end
    end
  endtask

  task automatic test_midscan_reset();
    int c;
    int n;
    apply_reset();
    pbus[0][1] = 1'b0;
    release_reset();
    repeat (27) @(negedge pclk);
    total++; if (joy_a[1] !== 1'b0 || valid_a !== 1'b1) begin bad++; $display("FAIL mid_pre joy1=%b valid=%b want 0/1", joy_a[1], valid_a); end
    n = 0;
    while (sel_a !== 1'b1 && n < 20) begin @(negedge pclk); n++; end
    total++; if (sel_a !== 1'b1) begin bad++; $display("FAIL mid_wait_sel1 got=%0d want=1", sel_a); end
    #2;
    pll_lckd = 1'b0;
    #1;
    total++; if (sel_a !== 1'b0 || sel_b !== 2'd0) begin bad++; $display("FAIL mid_sel got=%0d/%0d want=0/0", sel_a, sel_b); end
    total++; if (joy_a !== 16'hFFFF) begin bad++; $display("FAIL mid_joy_a got=%h want=ffff", joy_a); end
    total++; if (joy_b !== 24'hFFFFFF) begin bad++; $display("FAIL mid_joy_b got=%h want=ffffff", joy_b); end
    total++; if (valid_a !== 1'b0 || valid_b !== 1'b0 || done_a !== 1'b0) begin bad++; $display("FAIL mid_flags valid=%b%b done=%b", valid_a, valid_b, done_a); end
    @(negedge pclk);
    release_reset();
    repeat (30) begin
      @(negedge pclk);
      c = m_cyc;
      total++; if (sel_a !== 1'((c % 10) >= 5)) begin bad++; $display("FAIL mid_restart_sel cyc=%0d got=%0d", c, sel_a); end
      total++; if (joy_a[1] !== 1'(c < 25)) begin bad++; $display("FAIL mid_restart_a1 cyc=%0d got=%b want=%b", c, joy_a[1], c < 25); end
      total++; if (valid_a !== 1'(c >= 10)) begin bad++; $display("FAIL mid_restart_valid cyc=%0d got=%b", c, valid_a); end
    end
  endtask

  task automatic test_random();
    int c;
    int k;
    apply_reset();
    release_reset();
    repeat (1500) begin
      @(negedge pclk);
      c = m_cyc;
      total++; if (sel_a !== 1'(chan_of(0, c))) begin bad++; $display("FAIL rnd_sel_a cyc=%0d got=%0d want=%0d", c, sel_a, chan_of(0, c)); end
      total++; if (sel_b !== 2'(chan_of(1, c))) begin bad++; $display("FAIL rnd_sel_b cyc=%0d got=%0d want=%0d", c, sel_b, chan_of(1, c)); end
      total++; if (done_a !== exp_done(0, c) || done_b !== exp_done(1, c)) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b%b", c, done_a, done_b); end
      total++; if (valid_a !== exp_valid(0, c) || valid_b !== exp_valid(1, c)) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b%b", c, valid_a, valid_b); end
      total++; if (joy_a !== exp_joy_a()) begin bad++; $display("FAIL rnd_joy_a cyc=%0d got=%h want=%h", c, joy_a, exp_joy_a()); end
      total++; if (joy_b !== exp_joy_b()) begin bad++; $display("FAIL rnd_joy_b cyc=%0d got=%h want=%h", c, joy_b, exp_joy_b()); end
      if ($urandom_range(0, 15) == 0) begin
        k = int'($urandom_range(0, 3));
        pbus[k] = 8'($urandom);
      end
      if ($urandom_range(0, 31) == 0) local_joy = 6'($urandom);
    end
  endtask

  initial begin
    pbus      = '1;
    local_joy = '1;
    test_reset();
    test_settle_debounce();
    test_glitch();
    test_local_merge();
    test_wrap();
    test_midscan_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
